// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus a small MMIO block (GPIO,
// free-running cycle counter with compare flag, status, TOHOST/halt).
// Reads are combinational from the address; only writes change state.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_wrn,
    input  logic [15:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        cpu_halt,
    output logic [31:0] tohost_data
);

    localparam int RAM_AW = $clog2(DEPTH_WORDS);

    localparam logic [3:0] IDX_GPIO_OUT  = 4'd0;
    localparam logic [3:0] IDX_GPIO_IN   = 4'd1;
    localparam logic [3:0] IDX_CYCLE     = 4'd2;
    localparam logic [3:0] IDX_TIMER_CMP = 4'd3;
    localparam logic [3:0] IDX_STATUS    = 4'd4;
    localparam logic [3:0] IDX_TOHOST    = 4'd5;

    logic [31:0] ram [DEPTH_WORDS];

    logic [31:0] word_addr;
    logic [15:0] mmio_diff;
    logic [3:0]  mmio_idx;
    logic        is_ram;
    logic        is_mmio;
    logic        wr_en;
    logic        ram_we;
    logic        hole_we;
    logic [RAM_AW-1:0] ram_idx;

    logic [31:0] gpio_out_q;
    logic [31:0] gpio_sync1_q;
    logic [31:0] gpio_sync2_q;
    logic [31:0] cycle_q;
    logic [31:0] timer_cmp_q;
    logic        timer_flag_q;
    logic        halt_q;
    logic        bus_err_q;
    logic [31:0] tohost_q;

    logic        timer_match;
    logic        unused_addr_bits;

    // Address decode: RAM, 64-byte MMIO window, everything else is a hole.
    always_comb begin
        word_addr = {16'd0, mem_address[15:2], 2'b00};
        mmio_diff = word_addr[15:0] - MMIO_BASE;
        is_ram    = word_addr < 32'(4 * DEPTH_WORDS);
        is_mmio   = (word_addr[15:0] >= MMIO_BASE) && (mmio_diff[15:6] == 10'd0);
        mmio_idx  = mmio_diff[5:2];
        ram_idx   = mem_address[RAM_AW+1:2];
        wr_en     = !mem_read_wrn;
        ram_we    = wr_en && is_ram;
        hole_we   = wr_en && !is_ram && !is_mmio;
    end

    assign unused_addr_bits = ^{mem_address[1:0], mmio_diff[1:0]};
    assign timer_match      = (cycle_q == timer_cmp_q);

    // RAM word write; deliberately outside reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_wdata;
        end
    end

    // MMIO register state, counter, synchroniser and sticky status bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out_q   <= '0;
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
            cycle_q      <= '0;
            timer_cmp_q  <= '0;
            timer_flag_q <= 1'b0;
            halt_q       <= 1'b0;
            bus_err_q    <= 1'b0;
            tohost_q     <= '0;
        end else begin
            gpio_sync1_q <= gpio_in;
            gpio_sync2_q <= gpio_sync1_q;
            cycle_q      <= cycle_q + 32'd1;

            if (wr_en && is_mmio && mmio_idx == IDX_GPIO_OUT) begin
                gpio_out_q <= mem_wdata;
            end
            if (wr_en && is_mmio && mmio_idx == IDX_TIMER_CMP) begin
                timer_cmp_q <= mem_wdata;
            end
            if (wr_en && is_mmio && mmio_idx == IDX_TOHOST) begin
                tohost_q <= mem_wdata;
            end

            // Set sources take priority over a same-edge W1C.
            if (timer_match) begin
                timer_flag_q <= 1'b1;
            end else if (wr_en && is_mmio && mmio_idx == IDX_STATUS && mem_wdata[0]) begin
                timer_flag_q <= 1'b0;
            end

            if (hole_we) begin
                bus_err_q <= 1'b1;
            end else if (wr_en && is_mmio && mmio_idx == IDX_STATUS && mem_wdata[2]) begin
                bus_err_q <= 1'b0;
            end

            if ((wr_en && is_mmio && mmio_idx == IDX_STATUS && mem_wdata[1]) ||
                (wr_en && is_mmio && mmio_idx == IDX_TOHOST)) begin
                halt_q <= 1'b1;
            end
        end
    end

    // Combinational read mux; holes and unused MMIO offsets read zero.
    always_comb begin
        mem_rdata = '0;
        if (is_ram) begin
            mem_rdata = ram[ram_idx];
        end else if (is_mmio) begin
            case (mmio_idx)
                IDX_GPIO_OUT:  mem_rdata = gpio_out_q;
                IDX_GPIO_IN:   mem_rdata = gpio_sync2_q;
                IDX_CYCLE:     mem_rdata = cycle_q;
                IDX_TIMER_CMP: mem_rdata = timer_cmp_q;
                IDX_STATUS:    mem_rdata = {29'd0, bus_err_q, halt_q, timer_flag_q};
                IDX_TOHOST:    mem_rdata = tohost_q;
                default:       mem_rdata = '0;
            endcase
        end
    end

    assign gpio_out    = gpio_out_q;
    assign timer_irq   = timer_flag_q;
    assign cpu_halt    = halt_q;
    assign tohost_data = tohost_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, MMIO registers, timer,
// GPIO synchroniser, bus-error holes and TOHOST halt behaviour.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        mem_read_wrn;
    logic [15:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic        cpu_halt;
    logic [31:0] tohost_data;

    int checks   = 0;
    int failures = 0;
    int tb_cyc   = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(16'hFF00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read_wrn(mem_read_wrn),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .timer_irq   (timer_irq),
        .cpu_halt    (cpu_halt),
        .tohost_data (tohost_data)
    );

    always #5 clk = ~clk;

    // One clock edge; tb_cyc mirrors the CYCLE register value.
    task automatic tick();
        @(posedge clk);
        if (!rst) tb_cyc++;
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        mem_read_wrn = 1'b0;
        mem_address  = a;
        mem_wdata    = d;
        tick();
        mem_read_wrn = 1'b1;
        mem_address  = 16'h0000;
        mem_wdata    = 32'h0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        mem_read_wrn = 1'b1;
        mem_address  = a;
        #1;
        d = mem_rdata;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        tb_cyc = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst    = 1'b1;
        tb_cyc = 0;
        #1;
        checks++; if (gpio_out !== 32'h0) begin $display("FAIL rst_gpio_out got=%h exp=0", gpio_out); failures++; end
        checks++; if (timer_irq !== 1'b0) begin $display("FAIL rst_timer_irq got=%b exp=0", timer_irq); failures++; end
        checks++; if (cpu_halt !== 1'b0) begin $display("FAIL rst_cpu_halt got=%b exp=0", cpu_halt); failures++; end
        checks++; if (tohost_data !== 32'h0) begin $display("FAIL rst_tohost got=%h exp=0", tohost_data); failures++; end
        tick();
        rd(16'hFF08, d);
        checks++; if (d !== 32'h0) begin $display("FAIL rst_cycle got=%h exp=0", d); failures++; end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_ram();
        logic [31:0] d;
        do_reset();
        wr(16'h0014, 32'h1111_1111);
        wr(16'h0010, 32'hDEAD_BEEF);
        rd(16'h0010, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin $display("FAIL ram_rd_0010 got=%h exp=deadbeef", d); failures++; end
        rd(16'h0013, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin $display("FAIL ram_rd_0013 got=%h exp=deadbeef", d); failures++; end
        rd(16'h0014, d);
        checks++; if (d !== 32'h1111_1111) begin $display("FAIL ram_rd_0014 got=%h exp=11111111", d); failures++; end
        wr(16'h0FFC, 32'hCAFE_F00D);
        rd(16'h0FFC, d);
        checks++; if (d !== 32'hCAFE_F00D) begin $display("FAIL ram_last_word got=%h exp=cafef00d", d); failures++; end
    endtask

    task automatic test_subword_reset();
        logic [31:0] d;
        logic [15:0] offs [6];
        offs = '{16'hFF00, 16'hFF04, 16'hFF08, 16'hFF0C, 16'hFF10, 16'hFF14};
        wr(16'hFF00, 32'h0000_0077);
        wr(16'hFF0C, 32'h0000_0099);
        wr(16'h0020, 32'hFFFF_FF80);
        rd(16'h0020, d);
        checks++; if (d !== 32'hFFFF_FF80) begin $display("FAIL subword_store got=%h exp=ffffff80", d); failures++; end
        rst    = 1'b1;
        tb_cyc = 0;
        rd(16'h0020, d);
        checks++; if (d !== 32'hFFFF_FF80) begin $display("FAIL ram_retained got=%h exp=ffffff80", d); failures++; end
        for (int k = 0; k < 6; k++) begin
            rd(offs[k], d);
            checks++; if (d !== 32'h0) begin $display("FAIL mmio_rst_%0d got=%h exp=0", k, d); failures++; end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_timer();
        logic [31:0] d;
        do_reset();
        wr(16'hFF0C, 32'd5);
        // Reset CMP of 0 equals the reset CYCLE, so the first edge matches.
        checks++; if (timer_irq !== 1'b1) begin $display("FAIL timer_first_edge got=%b exp=1", timer_irq); failures++; end
        rd(16'hFF08, d);
        checks++; if (d !== 32'd1) begin $display("FAIL cycle_first got=%h exp=1", d); failures++; end
        wr(16'hFF10, 32'h1);
        checks++; if (timer_irq !== 1'b0) begin $display("FAIL timer_w1c got=%b exp=0", timer_irq); failures++; end
        while (tb_cyc < 5) tick();
        checks++; if (timer_irq !== 1'b0) begin $display("FAIL timer_early got=%b exp=0", timer_irq); failures++; end
        tick();
        checks++; if (timer_irq !== 1'b1) begin $display("FAIL timer_match5 got=%b exp=1", timer_irq); failures++; end
        rd(16'hFF08, d);
        checks++; if (d !== 32'd6) begin $display("FAIL cycle_6 got=%h exp=6", d); failures++; end
        wr(16'hFF10, 32'h1);
        wr(16'hFF0C, 32'd10);
        checks++; if (timer_irq !== 1'b0) begin $display("FAIL timer_clr2 got=%b exp=0", timer_irq); failures++; end
        while (tb_cyc < 10) tick();
        wr(16'hFF0C, 32'd50);
        checks++; if (timer_irq !== 1'b1) begin $display("FAIL timer_old_cmp got=%b exp=1", timer_irq); failures++; end
        rd(16'hFF0C, d);
        checks++; if (d !== 32'd50) begin $display("FAIL timer_cmp_rd got=%h exp=32", d); failures++; end
        wr(16'hFF10, 32'h1);
        checks++; if (timer_irq !== 1'b0) begin $display("FAIL timer_clr3 got=%b exp=0", timer_irq); failures++; end
        wr(16'hFF10, 32'h1);
        while (tb_cyc < 50) tick();
        wr(16'hFF10, 32'h1);
        checks++; if (timer_irq !== 1'b1) begin $display("FAIL timer_set_wins got=%b exp=1", timer_irq); failures++; end
        wr(16'hFF10, 32'h1);
        checks++; if (timer_irq !== 1'b0) begin $display("FAIL timer_clr4 got=%b exp=0", timer_irq); failures++; end
    endtask

    task automatic test_gpio();
        logic [31:0] d;
        gpio_in = 32'h1234_5678;
        rd(16'hFF04, d);
        checks++; if (d !== 32'h0) begin $display("FAIL gpio_in_e0 got=%h exp=0", d); failures++; end
        tick();
        rd(16'hFF04, d);
        checks++; if (d !== 32'h0) begin $display("FAIL gpio_in_e1 got=%h exp=0", d); failures++; end
        tick();
        rd(16'hFF04, d);
        checks++; if (d !== 32'h1234_5678) begin $display("FAIL gpio_in_e2 got=%h exp=12345678", d); failures++; end
        wr(16'hFF00, 32'h0000_00A5);
        checks++; if (gpio_out !== 32'h0000_00A5) begin $display("FAIL gpio_out got=%h exp=a5", gpio_out); failures++; end
        rd(16'hFF00, d);
        checks++; if (d !== 32'h0000_00A5) begin $display("FAIL gpio_out_rd got=%h exp=a5", d); failures++; end
        wr(16'hFF04, 32'h0);
        rd(16'hFF04, d);
        checks++; if (d !== 32'h1234_5678) begin $display("FAIL gpio_in_ro got=%h exp=12345678", d); failures++; end
    endtask

    task automatic test_hole();
        logic [31:0] d;
        do_reset();
        wr(16'hFF0C, 32'hFFFF_FFFF);
        wr(16'hFF10, 32'h1);
        wr(16'h0000, 32'h0BAD_C0DE);
        rd(16'hFF10, d);
        checks++; if (d !== 32'h0) begin $display("FAIL status_clean got=%h exp=0", d); failures++; end
        wr(16'hFF18, 32'hFFFF_FFFF);
        rd(16'hFF18, d);
        checks++; if (d !== 32'h0) begin $display("FAIL mmio_unused_rd got=%h exp=0", d); failures++; end
        rd(16'hFF10, d);
        checks++; if (d !== 32'h0) begin $display("FAIL mmio_unused_no_err got=%h exp=0", d); failures++; end
        wr(16'h8000, 32'h0000_0055);
        rd(16'h8000, d);
        checks++; if (d !== 32'h0) begin $display("FAIL hole_rd got=%h exp=0", d); failures++; end
        rd(16'hFF10, d);
        checks++; if (d !== 32'h4) begin $display("FAIL hole_status got=%h exp=4", d); failures++; end
        rd(16'h0000, d);
        checks++; if (d !== 32'h0BAD_C0DE) begin $display("FAIL hole_no_ram got=%h exp=0badc0de", d); failures++; end
        wr(16'hFF10, 32'h4);
        rd(16'hFF10, d);
        checks++; if (d !== 32'h0) begin $display("FAIL buserr_w1c got=%h exp=0", d); failures++; end
        wr(16'hFF40, 32'h1);
        rd(16'hFF10, d);
        checks++; if (d !== 32'h4) begin $display("FAIL hole_ff40 got=%h exp=4", d); failures++; end
        wr(16'hFF10, 32'h4);
        wr(16'h1000, 32'h7);
        rd(16'h1000, d);
        checks++; if (d !== 32'h0) begin $display("FAIL hole_1000_rd got=%h exp=0", d); failures++; end
        rd(16'hFF10, d);
        checks++; if (d !== 32'h4) begin $display("FAIL hole_1000_status got=%h exp=4", d); failures++; end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        do_reset();
        wr(16'hFF14, 32'h1);
        checks++; if (tohost_data !== 32'h1) begin $display("FAIL tohost got=%h exp=1", tohost_data); failures++; end
        checks++; if (cpu_halt !== 1'b1) begin $display("FAIL halt_set got=%b exp=1", cpu_halt); failures++; end
        for (int k = 0; k < 3; k++) begin
            wr(16'hFF14, 32'h1);
            checks++; if (tohost_data !== 32'h1 || cpu_halt !== 1'b1) begin
                $display("FAIL tohost_repeat_%0d got=%h/%b exp=1/1", k, tohost_data, cpu_halt); failures++;
            end
        end
        wr(16'hFF10, 32'h0);
        wr(16'hFF10, 32'h5);
        checks++; if (cpu_halt !== 1'b1) begin $display("FAIL halt_sticky got=%b exp=1", cpu_halt); failures++; end
        rd(16'hFF10, d);
        checks++; if (d !== 32'h2) begin $display("FAIL status_halt got=%h exp=2", d); failures++; end
        wr(16'hFF14, 32'h42);
        checks++; if (tohost_data !== 32'h42) begin $display("FAIL tohost_42 got=%h exp=42", tohost_data); failures++; end
        do_reset();
        checks++; if (cpu_halt !== 1'b0 || tohost_data !== 32'h0) begin
            $display("FAIL halt_rst got=%b/%h exp=0/0", cpu_halt, tohost_data); failures++;
        end
        wr(16'hFF10, 32'h2);
        checks++; if (cpu_halt !== 1'b1) begin $display("FAIL halt_w1s got=%b exp=1", cpu_halt); failures++; end
        checks++; if (tohost_data !== 32'h0) begin $display("FAIL w1s_tohost got=%h exp=0", tohost_data); failures++; end
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        mem_read_wrn = 1'b1;
        mem_address  = 16'h0000;
        mem_wdata    = 32'h0;
        gpio_in      = 32'h0;
        test_reset();
        test_ram();
        test_subword_reset();
        test_timer();
        test_gpio();
        test_hole();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
